ysyx_22050612_dmem_responder: RTL and testbench

- Data-memory responder: the memory side of the EXU load/store path.
- Accepts one read or write request at a time from the EXU/LSU over a valid/ready request channel, and returns one response over a valid/ready response channel after a fixed, configurable latency.
- Backed by an internal 64-bit-word SRAM array mapped at a base address; replaces DPI pmem access in synthesizable builds.

---
 rtl/ysyx_22050612_dmem_responder.sv | 133 +++++++++++++
 tb/tb_ysyx_22050612_dmem_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_dmem_responder.sv
// Data-memory responder: a single-outstanding valid/ready load/store port backed by a 64-bit-word array.
// Optional macro DMEM_RANGE_CHECK_EN turns out-of-range accesses into error responses instead of wrapping.
module ysyx_22050612_dmem_responder #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [63:0] BASE  = 64'h8000_0000,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_wen;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [7:0]    r_wmask;
  logic [63:0]   r_rdata;
  logic          r_err;
  logic [63:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_cur_wen;
  logic [63:0]   w_cur_addr;
  logic [63:0]   w_cur_wdata;
  logic [7:0]    w_cur_wmask;
  logic [63:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_we;
  logic          w_unused_bits;

  assign w_accept     = req_valid && req_ready;
  assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);

  // With LAT == 1 the commit happens on the accepting edge, so use the live request.
  assign w_cur_wen   = (r_state == S_IDLE) ? req_wen   : r_wen;
  assign w_cur_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_cur_wmask = (r_state == S_IDLE) ? req_wmask : r_wmask;

  assign w_off = w_cur_addr - BASE;
  assign w_idx = w_off[3 +: AW];

`ifdef DMEM_RANGE_CHECK_EN
  assign w_in_range = (w_cur_addr >= BASE) && ((w_off >> 3) < 64'(DEPTH));
`else
  assign w_in_range = 1'b1;
`endif

  assign w_unused_bits = &{1'b0, w_off[63:AW+3], w_off[2:0]};

  assign w_we = w_enter_resp && w_cur_wen && w_in_range && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = (LAT == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == CW'(1)) w_state_next = S_RESP;
      S_RESP: if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE) && !rst;
    rsp_valid = (r_state == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wen   <= req_wen;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wmask <= req_wmask;
        r_cnt   <= CW'(LAT - 1);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Response data is latched once on RESP entry and held until the requester takes it.
      if (w_enter_resp) begin
        r_rdata <= (!w_cur_wen && w_in_range) ? r_mem[w_idx] : 64'd0;
        r_err   <= !w_in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (w_cur_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_cur_wdata[8*b +: 8];
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_ysyx_22050612_dmem_responder.sv
// Directed bench for the data-memory responder: reset, latency, byte masks, backpressure, address range.
module tb_ysyx_22050612_dmem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] rd;

  always #5 clk = ~clk;

  ysyx_22050612_dmem_responder #(.DEPTH(1024), .BASE(64'h8000_0000), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request/response; hold = cycles of rsp_ready=0 while the response is pending.
  task automatic xact(input string name, input logic wen, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask, input int hold,
                      input bit chk, input logic [63:0] exp_rdata, input logic exp_err,
                      output logic [63:0] rdata);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check_val({name, " req_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    check_val({name, " latency"}, 64'(lat), 64'(LAT));
    rdata = rsp_rdata;
    if (chk) begin
      check_val({name, " rdata"}, rsp_rdata, exp_rdata);
      check_val({name, " err"}, 64'(rsp_err), 64'(exp_err));
    end
    req_wen = 1'b1; req_addr = addr; req_wdata = 64'd0; req_wmask = 8'hFF;
    for (int i = 0; i < hold; i++) begin
      check_val({name, " hold valid"}, 64'(rsp_valid), 64'd1);
      if (chk) check_val({name, " hold rdata"}, rsp_rdata, exp_rdata);
      check_val({name, " hold req_ready"}, 64'(req_ready), 64'd0);
      req_valid = (i == 2);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val({name, " rsp cleared"}, 64'(rsp_valid), 64'd0);
    $display("xact %s wen=%0d addr=%h wdata=%h wmask=%h -> rdata=%h lat=%0d",
             name, wen, addr, wdata, wmask, rdata, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_val("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("reset rsp_rdata", rsp_rdata, 64'd0);
    check_val("reset rsp_err", 64'(rsp_err), 64'd0);
    check_val("reset req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle req_ready", 64'(req_ready), 64'd1);

    // Reset while a write sits in WAIT: it must never commit or respond.
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0010;
    req_wdata = 64'h1122334455667788; req_wmask = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("midrst rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("midrst req_ready", 64'(req_ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check_val("inrst rsp_valid", 64'(rsp_valid), 64'd0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("postrst rsp_valid", 64'(rsp_valid), 64'd0);
    end
    $display("xact reset-abort write addr=8000000000000010 discarded");
    xact("rd_after_rst", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 1'b0, 64'd0, 1'b0, rd);
    check_val("rd_after_rst not committed", 64'(rd != 64'h1122334455667788), 64'd1);

    xact("wr8", 1'b1, 64'h8000_0008, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, 1'b1, 64'd0, 1'b0, rd);
    xact("rd8", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, 1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, rd);

    xact("wr0_clr", 1'b1, 64'h8000_0000, 64'd0, 8'hFF, 0, 1'b1, 64'd0, 1'b0, rd);
    xact("wr0_f0", 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 0, 1'b1, 64'd0, 1'b0, rd);
    xact("rd0", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0, rd);
    xact("rd4_alias", 1'b0, 64'h8000_0004, 64'd0, 8'h00, 0, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0, rd);
    xact("wr0_nomask", 1'b1, 64'h8000_0000, 64'h1234, 8'h00, 0, 1'b1, 64'd0, 1'b0, rd);
    xact("rd0_nomask", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0, rd);

    // Backpressure with a stray write pulse that must be ignored.
    xact("rd8_bp", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 5, 1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, rd);
    xact("rd8_again", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, 1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, rd);

`ifdef DMEM_RANGE_CHECK_EN
    xact("rd_hi_oor", 1'b0, 64'h8000_2000, 64'd0, 8'h00, 0, 1'b1, 64'd0, 1'b1, rd);
    xact("rd_lo_oor", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, 1'b1, 64'd0, 1'b1, rd);
    xact("wr_hi_oor", 1'b1, 64'h8000_2000, 64'h55, 8'hFF, 0, 1'b1, 64'd0, 1'b1, rd);
    xact("rd0_kept", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0, rd);
`else
    xact("wr_hi_wrap", 1'b1, 64'h8000_2000, 64'hAA, 8'hFF, 0, 1'b1, 64'd0, 1'b0, rd);
    xact("rd0_wrap", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, 1'b1, 64'hAA, 1'b0, rd);
    xact("wr_lo_wrap", 1'b1, 64'h7FFF_FFF8, 64'h77, 8'hFF, 0, 1'b1, 64'd0, 1'b0, rd);
    xact("rd_top_wrap", 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 0, 1'b1, 64'h77, 1'b0, rd);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
